sum_uart_tx: RTL and testbench
==============================

# sum_uart_tx

Serial transmitter for the adder result path. Latches two 8-bit operands on a start strobe and forms their 8-bit sum plus carry. Sends the sum LSB-first as an asynchronous serial frame on a single output line, to be routed to one dedicated output pin of the top-level wrapper. It is the outbound counterpart to the parallel operand inputs: results leave the chip serially instead of on eight parallel pins.

## Interface
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..65535; counter width is $clog2(CLKS_PER_BIT).
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- a  input  8  operand A, sampled only on the accepted start cycle.
- b  input  8  operand B, sampled only on the accepted start cycle.
- start  input  1  request to transmit a+b; level sampled each cycle.
- tx  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after the stop bit completes.
- carry  output  1  bit 8 of the last latched a+b; held until the next accepted start.

## Operation
- Reset values: tx=1, busy=0, done=0, carry=0, state=IDLE, bit and baud counters 0, shift register 0.
- Reset is asynchronous and aborts any frame immediately; tx returns high in the same instant.
- Sum: 9-bit a+b, unsigned; the low 8 bits load the shift register and bit 8 loads carry.
- State machine:
  - IDLE: start=1 -> latch sum/carry, load baud counter, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: tx = shift[0]; after each CLKS_PER_BIT cycles, shift right. After 8 bits -> PARITY if enabled, else STOP.
  - PARITY (optional): tx = even parity of the 8 sum bits, CLKS_PER_BIT cycles -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles -> IDLE with done=1.
- start while busy=1 is ignored, with no queueing; a/b changes during a frame have no effect.
- start held high continuously: a new frame is accepted on every IDLE cycle, giving back-to-back frames.
- tx is registered; it has no combinational path from any input.

## Timing
- Let N = 10 bits per frame (11 with parity) and C = CLKS_PER_BIT.
- start sampled high in IDLE at edge T:
  - T+1: tx=0, busy=1.
  - Data bit k is on tx during cycles T+1+(k+1)·C .. T+(k+2)·C.
  - busy stays high through cycle T+N·C.
  - T+N·C+1: busy=0, done=1 for exactly one cycle, state IDLE.
- A start sampled on the done cycle is accepted. Minimum frame-to-frame spacing is therefore N·C+1 cycles.
- carry updates at T+1 and is valid from then on.

## Configuration
- Macro SUM_TX_PARITY_EN.
- Defined: the PARITY state is compiled in and N=11. The parity bit is the XOR of the 8 sum bits (even parity) and is sent between the last data bit and the stop bit.
- Undefined: the PARITY state and its logic are absent, and the frame is start + 8 data + stop, so N=10.

## Test plan
- Reset: assert rst mid-frame with CLKS_PER_BIT=4 -> tx=1, busy=0, done=0 during rst. After release, start accepted normally.
- Basic frame, CLKS_PER_BIT=4, no parity: a=0x35, b=0x12, one-cycle start.
  - tx holds 0,1,1,1,0,0,0,1,0,1, each bit for 4 cycles, starting at T+1.
  - carry=0; done pulses at T+41; busy high for exactly 40 cycles.
- Carry: a=0xFF, b=0x02 -> data bits 0x01 (1,0,0,0,0,0,0,0), carry=1 from T+1.
- Ignored start: pulse start at T+5 while busy, with different operands -> frame content unchanged, no second frame, a single done pulse.
- Back-to-back: start held high, a=0xA0, b=0x0F -> second frame's start bit begins at T+42. tx never glitches high-to-low outside bit boundaries.
- Parity (SUM_TX_PARITY_EN defined): a=0x35, b=0x12 -> parity bit 0 at bits T+37..T+40, stop bit at T+41..T+44, done at T+45. With a=0x01, b=0x00 -> parity bit 1.

Source files
------------

// File: rtl/sum_uart_tx_if.sv
// Operand/strobe inputs and serial-line status outputs of sum_uart_tx.
// The master drives the operands and start; the slave (transmitter) drives tx and its flags.
interface sum_uart_tx_if;
    logic [7:0] a;
    logic [7:0] b;
    logic       start;
    logic       tx;
    logic       busy;
    logic       done;
    logic       carry;

    modport master (
        output a, b, start,
        input  tx, busy, done, carry
    );

    modport slave (
        input  a, b, start,
        output tx, busy, done, carry
    );
endinterface

// File: rtl/sum_uart_tx.sv
// Serialises a+b LSB-first as a start/8 data/[parity]/stop frame; parity bit when SUM_TX_PARITY_EN is defined.
// tx goes low one cycle after an accepted start; start while busy is dropped, not queued.
module sum_uart_tx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic         clk,
    input  logic         rst,
    sum_uart_tx_if.slave bus
);

    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef SUM_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          carry_q, carry_d;
`ifdef SUM_TX_PARITY_EN
    // Parity is captured at latch time because the shift register is consumed by DATA.
    logic          par_q, par_d;
`endif

    logic [8:0] sum;
    logic       baud_end;

    assign sum      = {1'b0, bus.a} + {1'b0, bus.b};
    assign baud_end = (baud_q == BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
`ifdef SUM_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            carry_q <= carry_d;
`ifdef SUM_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        carry_d = carry_q;
`ifdef SUM_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.start) begin
                    state_d = S_START;
                    baud_d  = '0;
                    bit_d   = '0;
                    shift_d = sum[7:0];
                    carry_d = sum[8];
`ifdef SUM_TX_PARITY_EN
                    par_d   = ^sum[7:0];
`endif
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
`ifdef SUM_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = par_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`ifdef SUM_TX_PARITY_EN
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (baud_end) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    baud_d = baud_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.tx    = tx_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.carry = carry_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx at CLKS_PER_BIT=4: directed table, reset/back-to-back sequences, random frames vs a frame model.
module tb_sum_uart_tx;

    localparam int C = 4;
`ifdef SUM_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] sum;
        logic       carry;
        int         inject;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    sum_uart_tx_if bus ();

    sum_uart_tx #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_check(input int n, input string nm);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s idle tx %0d", nm, i), 32'(bus.tx), 32'd1);
            chk($sformatf("%s idle busy %0d", nm, i), 32'(bus.busy), 32'd0);
            chk($sformatf("%s idle done %0d", nm, i), 32'(bus.done), 32'd0);
        end
    endtask

    // Expected line value for every cycle comes from the frame bit list: bit index = (cycle-1)/C.
    task automatic run_frame(input logic [7:0] fa, input logic [7:0] fb, input logic [7:0] exp_sum,
                             input logic exp_carry, input int inject, input bit hold, input string nm);
        logic frame [NB];
        frame[0] = 1'b0;
        for (int k = 0; k < 8; k++) frame[k+1] = exp_sum[k];
`ifdef SUM_TX_PARITY_EN
        frame[9] = ^exp_sum;
`endif
        frame[NB-1] = 1'b1;
        bus.a     = fa;
        bus.b     = fb;
        bus.start = 1'b1;
        step();
        for (int j = 1; j <= NB*C + 1; j++) begin
            if (j == inject) begin
                bus.start = 1'b1;
                bus.a     = fa ^ 8'h5A;
                bus.b     = fb + 8'd3;
            end else if (!hold) begin
                bus.start = 1'b0;
                if (j >= 2) begin
                    bus.a = 8'($urandom);
                    bus.b = 8'($urandom);
                end
            end
            if (j <= NB*C) begin
                chk($sformatf("%s tx cyc%0d", nm, j), 32'(bus.tx), 32'(frame[(j-1)/C]));
                chk($sformatf("%s busy cyc%0d", nm, j), 32'(bus.busy), 32'd1);
                chk($sformatf("%s done cyc%0d", nm, j), 32'(bus.done), 32'd0);
            end else begin
                chk($sformatf("%s tx at done", nm), 32'(bus.tx), 32'd1);
                chk($sformatf("%s busy at done", nm), 32'(bus.busy), 32'd0);
                chk($sformatf("%s done pulse", nm), 32'(bus.done), 32'd1);
            end
            if (j == 1 || j == NB*C + 1)
                chk($sformatf("%s carry cyc%0d", nm, j), 32'(bus.carry), 32'(exp_carry));
            if (j <= NB*C) step();
        end
    endtask

    initial begin
        vec_t       vecs [7];
        logic [8:0] t;
        logic [7:0] ra, rb;
        int         inj;

        vecs[0] = '{a: 8'h35, b: 8'h12, sum: 8'h47, carry: 1'b0, inject: 0};
        vecs[1] = '{a: 8'hFF, b: 8'h02, sum: 8'h01, carry: 1'b1, inject: 0};
        vecs[2] = '{a: 8'h35, b: 8'h12, sum: 8'h47, carry: 1'b0, inject: 5};
        vecs[3] = '{a: 8'h01, b: 8'h00, sum: 8'h01, carry: 1'b0, inject: 0};
        vecs[4] = '{a: 8'h80, b: 8'h80, sum: 8'h00, carry: 1'b1, inject: 0};
        vecs[5] = '{a: 8'hFF, b: 8'hFF, sum: 8'hFE, carry: 1'b1, inject: 0};
        vecs[6] = '{a: 8'h00, b: 8'h00, sum: 8'h00, carry: 1'b0, inject: 0};

        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.a     = 8'h00;
        bus.b     = 8'h00;
        bus.start = 1'b0;
        step();
        step();
        chk("reset tx", 32'(bus.tx), 32'd1);
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset carry", 32'(bus.carry), 32'd0);
        rst = 1'b0;
        idle_check(2, "post reset");

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].a, vecs[i].b, vecs[i].sum, vecs[i].carry, vecs[i].inject, 1'b0,
                      $sformatf("vec%0d", i));
            idle_check(3, $sformatf("vec%0d", i));
        end

        // Start held high: the second frame is accepted on the done cycle.
        run_frame(8'hA0, 8'h0F, 8'hAF, 1'b0, 0, 1'b1, "b2b first");
        run_frame(8'hA0, 8'h0F, 8'hAF, 1'b0, 0, 1'b1, "b2b second");
        bus.start = 1'b0;
        idle_check(2, "b2b");

        // Asynchronous reset in the middle of a carry=1 frame.
        bus.a     = 8'hFF;
        bus.b     = 8'h02;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) step();
        chk("midframe busy", 32'(bus.busy), 32'd1);
        chk("midframe carry", 32'(bus.carry), 32'd1);
        #2;
        rst       = 1'b1;
        bus.start = 1'b1;
        #1;
        chk("async rst tx", 32'(bus.tx), 32'd1);
        chk("async rst busy", 32'(bus.busy), 32'd0);
        chk("async rst done", 32'(bus.done), 32'd0);
        chk("async rst carry", 32'(bus.carry), 32'd0);
        step();
        chk("held rst tx", 32'(bus.tx), 32'd1);
        chk("held rst busy", 32'(bus.busy), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        idle_check(2, "after rst");
        run_frame(8'h35, 8'h12, 8'h47, 1'b0, 0, 1'b0, "after rst");
        idle_check(2, "after rst frame");

        for (int i = 0; i < 30; i++) begin
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            t   = {1'b0, ra} + {1'b0, rb};
            inj = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, NB*C)) : 0;
            run_frame(ra, rb, t[7:0], t[8], inj, 1'b0, $sformatf("rand%0d", i));
            idle_check(int'($urandom_range(0, 2)), $sformatf("rand%0d", i));
        end
        idle_check(2, "final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
